// File: rtl/miner_pkg.sv
// miner_pkg: shared state encoding and widths for the nonce scheduler.
package miner_pkg;
  typedef enum logic [1:0] {IDLE, RUN, REPORT, DONE} state_t;
  localparam int CYCLE_W    = 6;
  localparam int CORE_OUT_W = 33;
  localparam int NONCE_W    = 32;
endpackage

// File: rtl/nonce_scheduler_lsb_pick.sv
// lsb_pick: lowest-set-bit priority encoder (req -> idx of lowest set bit, any = some bit set).
module lsb_pick #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
  end
  assign any = |req;
endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: sweeps a nonce range across NUM_CORES sha cores and reports flagged nonces.
//   start/abort/nonce_start/nonce_end: sweep control; core_result: packed {flag,nonce} per core
//   cycle/nonce: round counter and base nonce to cores; busy/done: status
//   found_valid/found_nonce/found_ack: result handshake; found_count: saturating report count
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int RESULT_CYCLE = 63
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NONCE_W-1:0]              nonce_start,
  input  logic [NONCE_W-1:0]              nonce_end,
  input  logic [CORE_OUT_W*NUM_CORES-1:0] core_result,
  output logic [CYCLE_W-1:0]              cycle,
  output logic [NONCE_W-1:0]              nonce,
  output logic                            busy,
  output logic                            done,
  output logic                            found_valid,
  output logic [NONCE_W-1:0]              found_nonce,
  input  logic                            found_ack,
  output logic [15:0]                     found_count
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  state_t                            state_q, state_d;
  logic [CYCLE_W-1:0]                cycle_q, cycle_d;
  logic [NONCE_W-1:0]                nonce_q, nonce_d, end_q, end_d;
  logic                              last_q, last_d;
  logic [NUM_CORES-1:0]              mask_q, mask_d, flags, mask_rest;
  logic [NUM_CORES-1:0][NONCE_W-1:0] cap_q, cap_d, core_nonce;
  logic [15:0]                       count_q, count_d;
  logic [IW-1:0]                     idx;
  logic                              any, go, res, acc, pass_last;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign flags[g]      = core_result[CORE_OUT_W*g+NONCE_W];
    assign core_nonce[g] = core_result[CORE_OUT_W*g +: NONCE_W];
  end

  lsb_pick #(.W(NUM_CORES)) u_pick (.req(mask_q), .idx(idx), .any(any));

  // abort outranks every other event, so each event qualifier excludes it
  assign go        = start && !abort && (state_q == IDLE || state_q == DONE);
  assign res       = !abort && state_q == RUN && cycle_q == CYCLE_W'(RESULT_CYCLE);
  assign acc       = !abort && found_valid && found_ack;
  assign mask_rest = mask_q & ~(NUM_CORES'(1) << idx);
  // 33-bit compare so a pass that wraps past FFFFFFFF still terminates the sweep
  assign pass_last = ({1'b0, nonce_q} + (NONCE_W+1)'(NUM_CORES)) > {1'b0, end_q};

  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else if (go) state_d = RUN;
    else if (res) state_d = |flags ? REPORT : pass_last ? DONE : RUN;
    else if (acc && mask_rest == '0) state_d = last_q ? DONE : RUN;
    cycle_d = (state_q == RUN && !res && !abort) ? cycle_q + CYCLE_W'(1) : '0;
    nonce_d = res ? nonce_q + NONCE_W'(NUM_CORES) : go ? nonce_start : nonce_q;
    end_d   = go ? nonce_end : end_q;
    last_d  = res ? pass_last : go ? 1'b0 : last_q;
    mask_d  = abort ? '0 : res ? flags : acc ? mask_rest : mask_q;
    cap_d   = res ? core_nonce : cap_q;
    count_d = go ? '0 : (acc && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cycle_q <= '0;
      nonce_q <= '0;
      end_q   <= '0;
      last_q  <= 1'b0;
      mask_q  <= '0;
      cap_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      nonce_q <= nonce_d;
      end_q   <= end_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      count_q <= count_d;
    end
  end

  assign cycle       = cycle_q;
  assign nonce       = nonce_q;
  assign busy        = state_q == RUN || state_q == REPORT;
  assign done        = state_q == DONE;
  assign found_valid = state_q == REPORT && any;
  assign found_nonce = found_valid ? cap_q[idx] : '0;
  assign found_count = count_q;
endmodule
